picorv32_mem_arbiter: RTL and testbench

//  Shares one native-picorv32 memory port between two requesters: m0 (the picorv32 core mem_* bus)
//  and m1 (a harness/fuzzer or DMA injector). It sits between the core and the memory model.
//  One transaction is outstanding at a time. Requesters are served round-robin.
//  The memory-side request is registered. A watchdog aborts a transfer when s_ready never comes.

---
 rtl/picorv32_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_picorv32_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/picorv32_mem_arbiter.sv
// rtl/picorv32_mem_arbiter.sv - two-requester arbiter for one native picorv32 memory port
//
// Purpose:
//   Shares a single picorv32-style memory port between m0 (the core) and m1
//   (a harness or DMA injector). Only one transfer is in flight at a time.
//   Ties are resolved round-robin, or always in m0's favour when FIXED_PRI=1.
//   A watchdog aborts a transfer whose s_ready never arrives. The aborted
//   requester receives an all-ones read word and a timeout_err pulse.
//
// Ports:
//   clk, reset           clock and asynchronous active-high reset
//   m0_* / m1_*          requester buses: valid/addr/wdata/wstrb in, ready/rdata out
//   s_*                  registered memory-side request, s_ready/s_rdata back
//   grant_id             owner of the current or most recent transfer
//   busy                 high whenever the FSM is outside IDLE
//   timeout_err          one-cycle pulse, coincident with the aborted ready
module picorv32_mem_arbiter #(
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int TIMEOUT   = 255,
    parameter int FIXED_PRI = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            m0_valid,
    input  logic [AW-1:0]   m0_addr,
    input  logic [DW-1:0]   m0_wdata,
    input  logic [DW/8-1:0] m0_wstrb,
    output logic            m0_ready,
    output logic [DW-1:0]   m0_rdata,
    input  logic            m1_valid,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wstrb,
    output logic            m1_ready,
    output logic [DW-1:0]   m1_rdata,
    output logic            s_valid,
    output logic [AW-1:0]   s_addr,
    output logic [DW-1:0]   s_wdata,
    output logic [DW/8-1:0] s_wstrb,
    input  logic            s_ready,
    input  logic [DW-1:0]   s_rdata,
    output logic            grant_id,
    output logic            busy,
    output logic            timeout_err
);

    // A 1-bit counter is kept even when the watchdog is disabled so the
    // declaration stays legal; it is never compared in that case.
    localparam int WDOG_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(TIMEOUT);
    localparam logic [WDOG_W-1:0] WDOG_ONE = WDOG_W'(1);
    localparam logic [WDOG_W-1:0] WDOG_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_last_grant;
    logic [WDOG_W-1:0]   r_wdog;
    logic                w_pick;
    logic                w_timeout;

    // Winner for the IDLE grant: a lone requester wins outright. On a tie,
    // fixed priority favours m0; round-robin favours whoever did not win last.
    always_comb begin
        w_pick = 1'b0;
        if (m0_valid && m1_valid) begin
            w_pick = (FIXED_PRI != 0) ? 1'b0 : ~r_last_grant;
        end else if (m1_valid) begin
            w_pick = 1'b1;
        end
    end

    assign w_timeout = (TIMEOUT != 0) && (r_wdog == WDOG_LIM);
    assign busy      = (r_state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_wdog       <= '0;
            grant_id     <= 1'b0;
            s_valid      <= 1'b0;
            s_addr       <= '0;
            s_wdata      <= '0;
            s_wstrb      <= '0;
            m0_ready     <= 1'b0;
            m1_ready     <= 1'b0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
            timeout_err  <= 1'b0;
        end else begin
            // Ready, read data and timeout are single-cycle pulses by default.
            m0_ready    <= 1'b0;
            m1_ready    <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
            timeout_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (m0_valid || m1_valid) begin
                        grant_id     <= w_pick;
                        r_last_grant <= w_pick;
                        s_valid      <= 1'b1;
                        s_addr       <= w_pick ? m1_addr  : m0_addr;
                        s_wdata      <= w_pick ? m1_wdata : m0_wdata;
                        s_wstrb      <= w_pick ? m1_wstrb : m0_wstrb;
                        r_state      <= ST_XFER;
                    end
                end

                ST_XFER: begin
                    // s_ready wins over a simultaneous watchdog expiry.
                    if (s_ready) begin
                        s_valid <= 1'b0;
                        if (grant_id) begin
                            m1_ready <= 1'b1;
                            m1_rdata <= s_rdata;
                        end else begin
                            m0_ready <= 1'b1;
                            m0_rdata <= s_rdata;
                        end
                        r_state <= ST_DONE;
                    end else if (w_timeout) begin
                        s_valid     <= 1'b0;
                        timeout_err <= 1'b1;
                        if (grant_id) begin
                            m1_ready <= 1'b1;
                            m1_rdata <= '1;
                        end else begin
                            m0_ready <= 1'b1;
                            m0_rdata <= '1;
                        end
                        r_state <= ST_DONE;
                    end else if (r_wdog != WDOG_MAX) begin
                        r_wdog <= r_wdog + WDOG_ONE;
                    end
                end

                ST_DONE: begin
                    // Dead cycle lets the served requester drop valid before
                    // the next arbitration.
                    r_wdog  <= '0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// tb/tb_picorv32_mem_arbiter.sv - self-checking bench for picorv32_mem_arbiter
module tb_picorv32_mem_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          m0_valid, m1_valid, m0_ready, m1_ready;
    logic [AW-1:0] m0_addr, m1_addr, s_addr;
    logic [DW-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, s_wdata, s_rdata;
    logic [3:0]    m0_wstrb, m1_wstrb, s_wstrb;
    logic          s_valid, s_ready, grant_id, busy, timeout_err;

    logic          b_m0_valid, b_m1_valid, b_m0_ready, b_m1_ready;
    logic [DW-1:0] b_m0_rdata, b_m1_rdata, b_s_wdata;
    logic [AW-1:0] b_s_addr;
    logic [3:0]    b_s_wstrb;
    logic          b_s_valid, b_s_ready, b_grant_id, b_busy, b_timeout_err;
    logic          b_mem_en;
    assign b_s_ready = b_s_valid & b_mem_en;

    picorv32_mem_arbiter #(.DW(DW), .AW(AW), .TIMEOUT(TMO), .FIXED_PRI(0)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    picorv32_mem_arbiter #(.DW(DW), .AW(AW), .TIMEOUT(0), .FIXED_PRI(1)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_valid(b_m0_valid), .m0_addr(32'h0000_0010), .m0_wdata(32'h0), .m0_wstrb(4'h0),
        .m0_ready(b_m0_ready), .m0_rdata(b_m0_rdata),
        .m1_valid(b_m1_valid), .m1_addr(32'h0000_0020), .m1_wdata(32'h0), .m1_wstrb(4'h0),
        .m1_ready(b_m1_ready), .m1_rdata(b_m1_rdata),
        .s_valid(b_s_valid), .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb),
        .s_ready(b_s_ready), .s_rdata(32'hCAFE_0000),
        .grant_id(b_grant_id), .busy(b_busy), .timeout_err(b_timeout_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        v0;
        logic        v1;
        int          wait_n;
        logic [31:0] rdata;
        logic        exp_gid;
        int          exp_lat;
        logic [31:0] exp_rd;
        logic        exp_tmo;
    } vec_t;

    vec_t vecs[10];

    // One transaction from a quiet IDLE: request at cycle 0, memory answers
    // at XFER cycle index wait_n, latency is counted to the ready pulse.
    task automatic run_vec(input vec_t v, input int idx);
        int cyc, xc, lat;
        logic [1:0] rdy;
        logic [31:0] rd;
        logic tmo;
        bit got;
        cyc = 0; xc = -1; lat = -1; rdy = 2'b00; rd = 32'h0; tmo = 1'b0; got = 0;
        m0_valid = v.v0; m0_addr = 32'h1000 + idx; m0_wdata = 32'h11 * idx; m0_wstrb = 4'h0;
        m1_valid = v.v1; m1_addr = 32'h2000 + idx; m1_wdata = 32'h22 * idx; m1_wstrb = 4'h0;
        s_rdata = v.rdata; s_ready = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check($sformatf("v%0d_gid", idx), grant_id, v.exp_gid);
                check($sformatf("v%0d_svalid", idx), s_valid, 1'b1);
                check($sformatf("v%0d_saddr", idx), s_addr,
                      v.exp_gid ? 32'h2000 + idx : 32'h1000 + idx);
            end
            if (s_valid) xc++;
            s_ready = s_valid && (xc == v.wait_n);
            if (m0_ready || m1_ready) begin
                got = 1;
                lat = cyc;
                rdy = {m1_ready, m0_ready};
                rd  = v.exp_gid ? m1_rdata : m0_rdata;
                tmo = timeout_err;
                check($sformatf("v%0d_other_rdata", idx), v.exp_gid ? m0_rdata : m1_rdata, 32'h0);
            end
        end
        check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d_ready", idx), rdy, v.exp_gid ? 2'b10 : 2'b01);
        check($sformatf("v%0d_rdata", idx), rd, v.exp_rd);
        check($sformatf("v%0d_tmo", idx), tmo, v.exp_tmo);
        m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_idle", idx), {busy, m0_ready, m1_ready}, 3'b000);
    endtask

    // Transaction-level reference for the random phase: each grant occupies
    // L = min(wait, TMO)+1 request cycles, one ready cycle, then frees the port.
    logic         pend [2];
    logic [31:0]  r_addr [2];
    logic [31:0]  r_wdata [2];
    logic [3:0]   r_wstrb [2];
    logic         vld [2];
    bit           active;
    int           g_cyc, len, wsel, busy_until, c;
    logic         owner, m_last, m_gid, e_tmo;
    logic [31:0]  e_rdv, l_addr, l_wdata;
    logic [3:0]   l_wstrb;
    logic [5:0]   e_ctl;
    logic [31:0]  e_rd0, e_rd1;
    bit           chk_s;
    int           n_grants, n_tmo;

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1;
        m0_valid = 0; m1_valid = 0; m0_addr = 0; m1_addr = 0;
        m0_wdata = 0; m1_wdata = 0; m0_wstrb = 0; m1_wstrb = 0;
        s_ready = 0; s_rdata = 0;
        b_m0_valid = 0; b_m1_valid = 0; b_mem_en = 0;

        vecs[0] = '{1'b1, 1'b0, 2, 32'h1234_5678, 1'b0, 4, 32'h1234_5678, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 0, 32'hA5A5_A5A5, 1'b1, 2, 32'hA5A5_A5A5, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 0, 32'h5A5A_5A5A, 1'b0, 2, 32'h5A5A_5A5A, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1, 32'h0000_0003, 1'b1, 3, 32'h0000_0003, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 3, 32'h0000_0004, 1'b0, 5, 32'h0000_0004, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 4, 32'h0BAD_F00D, 1'b1, 6, 32'h0BAD_F00D, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 9, 32'h7777_7777, 1'b0, 6, 32'hFFFF_FFFF, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 0, 32'h0000_0007, 1'b1, 2, 32'h0000_0007, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 0, 32'h0000_0008, 1'b1, 2, 32'h0000_0008, 1'b0};
        vecs[9] = '{1'b1, 1'b1, 0, 32'h0000_0009, 1'b0, 2, 32'h0000_0009, 1'b0};

        repeat (2) @(negedge clk);
        check("reset_ctl", {s_valid, busy, grant_id, m0_ready, m1_ready, timeout_err}, 6'b0);
        check("reset_rdata", {m0_rdata, m1_rdata}, 64'h0);
        check("reset_sbus", {s_addr, s_wdata, s_wstrb}, 68'h0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_idle", {s_valid, busy, m0_ready, m1_ready}, 4'b0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // m1 write: request fields must be latched and stable through XFER.
        m1_valid = 1; m1_addr = 32'h100; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'b0011;
        s_ready = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("wr_sbus_%0d", k), {s_addr, s_wdata, s_wstrb},
                  {32'h100, 32'hDEAD_BEEF, 4'b0011});
            check($sformatf("wr_ctl_%0d", k), {s_valid, grant_id, m0_ready, m1_ready}, 4'b1100);
            m1_addr = 32'hFFF; m1_wdata = 32'h0; m1_wstrb = 4'hF;
            s_ready = (k == 4);
        end
        @(negedge clk);
        check("wr_ready", {m1_ready, m0_ready, s_valid}, 3'b100);
        m1_valid = 0; s_ready = 1;
        @(negedge clk);
        check("wr_pulse_end", {m1_ready, m0_ready}, 2'b00);
        @(negedge clk);
        check("sready_ignored", {busy, s_valid, m0_ready, m1_ready}, 4'b0);
        s_ready = 0;

        // Async reset while a transfer is in flight.
        m0_valid = 1; m0_addr = 32'h40; m0_wstrb = 4'h0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_xfer", {s_valid, busy}, 2'b11);
        #2 reset = 1'b1;
        #1 check("async_rst", {s_valid, busy, grant_id, m0_ready, m1_ready, timeout_err, s_addr}, 38'h0);
        m0_valid = 0;
        @(negedge clk);
        reset = 1'b0;
        check("rst_no_ready", {m0_ready, m1_ready}, 2'b00);

        // Both requesters held valid with zero-wait memory: strict alternation from m0.
        m0_valid = 1; m1_valid = 1;
        begin
            int n;
            logic prev;
            n = 0; prev = 1'b0;
            for (int k = 0; k < 60 && n < 8; k++) begin
                @(negedge clk);
                if (s_valid && !prev) begin
                    check($sformatf("rr_%0d", n), grant_id, n[0]);
                    n++;
                end
                prev = s_valid;
                s_ready = s_valid;
            end
            check("rr_count", n, 8);
        end
        m0_valid = 0; m1_valid = 0; s_ready = 0;
        repeat (3) @(negedge clk);

        // Randomized traffic against the transaction-level reference.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pend[0] = 0; pend[1] = 0; active = 0; g_cyc = 0; len = 0; wsel = 0;
        busy_until = -1; owner = 0; m_last = 1; m_gid = 0; e_tmo = 0; e_rdv = 0;
        l_addr = 0; l_wdata = 0; l_wstrb = 0; n_grants = 0; n_tmo = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            c = cyc - g_cyc;
            e_rd0 = 32'h0; e_rd1 = 32'h0; chk_s = 0;
            if (active && c >= 1 && c <= len) begin
                e_ctl = {1'b1, 1'b1, owner, 3'b000};
                chk_s = 1;
            end else if (active && c == len + 1) begin
                e_ctl = {1'b0, 1'b1, owner, !owner, owner, e_tmo};
                if (owner) e_rd1 = e_rdv; else e_rd0 = e_rdv;
            end else begin
                e_ctl = {1'b0, 1'b0, m_gid, 3'b000};
            end
            check($sformatf("rnd_ctl@%0d", cyc),
                  {s_valid, busy, grant_id, m0_ready, m1_ready, timeout_err}, e_ctl);
            check($sformatf("rnd_rdata@%0d", cyc), {m0_rdata, m1_rdata}, {e_rd0, e_rd1});
            if (chk_s)
                check($sformatf("rnd_sbus@%0d", cyc), {s_addr, s_wdata, s_wstrb},
                      {l_addr, l_wdata, l_wstrb});
            if (active && c == len + 1) begin
                active = 0;
                pend[owner] = 0;
            end

            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && !(active && owner == i) && $urandom_range(0, 3) == 0) begin
                    pend[i]    = 1;
                    r_addr[i]  = $urandom;
                    r_wdata[i] = $urandom;
                    r_wstrb[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
                end
                vld[i] = (active && owner == i) ? 1'($urandom_range(0, 1)) : pend[i];
            end
            m0_valid = vld[0]; m0_addr = r_addr[0]; m0_wdata = r_wdata[0]; m0_wstrb = r_wstrb[0];
            m1_valid = vld[1]; m1_addr = r_addr[1]; m1_wdata = r_wdata[1]; m1_wstrb = r_wstrb[1];

            if (cyc > busy_until && (vld[0] || vld[1])) begin
                if (vld[0] && vld[1]) owner = !m_last;
                else owner = vld[1];
                m_last = owner; m_gid = owner;
                l_addr = r_addr[owner]; l_wdata = r_wdata[owner]; l_wstrb = r_wstrb[owner];
                wsel = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO, TMO + 4) : $urandom_range(0, 3);
                e_tmo = (wsel > TMO);
                len = e_tmo ? TMO + 1 : wsel + 1;
                e_rdv = e_tmo ? 32'hFFFF_FFFF : $urandom;
                g_cyc = cyc;
                busy_until = cyc + len + 1;
                active = 1;
                n_grants++;
                if (e_tmo) n_tmo++;
            end

            c = cyc - g_cyc;
            if (active && c >= 1 && c <= len) begin
                s_ready = !e_tmo && (c == wsel + 1);
                s_rdata = s_ready ? e_rdv : $urandom;
            end else begin
                s_ready = 1'($urandom_range(0, 1));
                s_rdata = $urandom;
            end
        end
        check("rnd_grants_seen", n_grants > 100, 1'b1);
        check("rnd_timeouts_seen", n_tmo > 3, 1'b1);
        m0_valid = 0; m1_valid = 0; s_ready = 0;

        // Fixed-priority instance, watchdog disabled.
        b_m0_valid = 1; b_m1_valid = 1; b_mem_en = 1;
        begin
            int grants;
            grants = 0;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                if (b_busy) check($sformatf("fp_gid@%0d", k), b_grant_id, 1'b0);
                check($sformatf("fp_m1_starved@%0d", k), b_m1_ready, 1'b0);
                if (b_m0_ready) begin
                    grants++;
                    check($sformatf("fp_rdata@%0d", k), b_m0_rdata, 32'hCAFE_0000);
                end
            end
            check("fp_grant_count", grants >= 18, 1'b1);
        end
        b_mem_en = 0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            check($sformatf("nowdog@%0d", k), {b_timeout_err, b_m0_ready, b_m1_ready}, 3'b000);
        end
        check("nowdog_still_busy", {b_busy, b_s_valid, b_grant_id}, 3'b110);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
